// File: rtl/labfinalsoc_usb_rst_seq.sv
// Avalon-MM slave that drives the external USB chip reset pin through a timed
// assert/settle sequence, with sticky status, overrun flag and completion interrupt.
module labfinalsoc_usb_rst_seq #(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned DEF_ASSERT = 50000,
  parameter int unsigned DEF_SETTLE = 100000,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        usb_rst_n,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ASSERT = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_ASSERT = 2'd1;
  localparam logic [1:0] A_SETTLE = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] settle_lat;
  logic [CNT_W-1:0] assert_reg;
  logic [CNT_W-1:0] settle_reg;
  logic             hold;
  logic             irq_en;
  logic             done;
  logic             ovr;
  logic [7:0]       seq_cnt;
  logic             auto_pend;

  logic             wr;
  logic             wr_ctrl;
  logic             wr_assert;
  logic             wr_settle;
  logic             wr_status;
  logic             start_req;
  logic             busy;
  logic [CNT_W-1:0] assert_len;
  logic [CNT_W-1:0] settle_len;
  logic             unused_wdata;

  assign wr         = chipselect & ~write_n;
  assign wr_ctrl    = wr && (address == A_CTRL);
  assign wr_assert  = wr && (address == A_ASSERT);
  assign wr_settle  = wr && (address == A_SETTLE);
  assign wr_status  = wr && (address == A_STATUS);
  // The pending auto-start makes the first post-reset cycle look like a start write.
  assign start_req  = (wr_ctrl & writedata[0]) | auto_pend;
  assign busy       = (state != S_IDLE);
  assign assert_len = (assert_reg == '0) ? CNT_W'(1) : assert_reg;
  assign settle_len = (settle_reg == '0) ? CNT_W'(1) : settle_reg;
  assign unused_wdata = ^writedata;

  assign usb_rst_n = ~((state == S_ASSERT) | hold);
  assign irq       = done & irq_en;

  // Register file, sequencer FSM and sticky status; sets are written last so they win over W1C.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      settle_lat <= '0;
      assert_reg <= CNT_W'(DEF_ASSERT);
      settle_reg <= CNT_W'(DEF_SETTLE);
      hold       <= 1'b0;
      irq_en     <= 1'b0;
      done       <= 1'b0;
      ovr        <= 1'b0;
      seq_cnt    <= '0;
      auto_pend  <= AUTO_START;
    end else begin
      auto_pend <= 1'b0;
      if (wr_ctrl) begin
        hold   <= writedata[1];
        irq_en <= writedata[2];
      end
      if (wr_assert) assert_reg <= writedata[CNT_W-1:0];
      if (wr_settle) settle_reg <= writedata[CNT_W-1:0];
      if (wr_status) begin
        if (writedata[1]) done <= 1'b0;
        if (writedata[2]) ovr  <= 1'b0;
      end
      case (state)
        S_IDLE: begin
          if (start_req) begin
            state      <= S_ASSERT;
            cnt        <= assert_len;
            settle_lat <= settle_len;
          end
        end
        S_ASSERT: begin
          if (start_req) ovr <= 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= S_SETTLE;
            cnt   <= settle_lat;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_SETTLE: begin
          if (start_req) ovr <= 1'b1;
          if (cnt == CNT_W'(1)) begin
            state   <= S_IDLE;
            cnt     <= '0;
            done    <= 1'b1;
            seq_cnt <= seq_cnt + 8'd1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Zero-wait-state read mux, always decoded from address.
  always_comb begin
    readdata = '0;
    case (address)
      A_CTRL:   readdata[2:1] = {irq_en, hold};
      A_ASSERT: readdata      = 32'(assert_reg);
      A_SETTLE: readdata      = 32'(settle_reg);
      A_STATUS: begin
        readdata[0]    = busy;
        readdata[1]    = done;
        readdata[2]    = ovr;
        readdata[5:4]  = state;
        readdata[15:8] = seq_cnt;
      end
      default:  readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_labfinalsoc_usb_rst_seq.sv
// Bench for the USB reset sequencer: expected low-pulse lengths are queued when a
// sequence is launched and popped when the pin monitor sees each pulse end.
module tb_labfinalsoc_usb_rst_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        usb_rst_n;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int exp_seq = 0;
  bit mon_en = 1'b1;
  int low_run = 0;

  labfinalsoc_usb_rst_seq #(
    .CNT_W(24), .DEF_ASSERT(4), .DEF_SETTLE(3), .AUTO_START(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .usb_rst_n(usb_rst_n), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pin monitor: measure each low pulse and compare with the queued expectation.
  always @(negedge clk) begin
    if (usb_rst_n === 1'b0) begin
      low_run++;
    end else begin
      if (low_run > 0 && mon_en) begin
        if (exp_q.size() == 0) check("pulse_unexpected", 32'(low_run), 32'd0);
        else check("pulse_len", 32'(low_run), 32'(exp_q.pop_front()));
      end
      low_run = 0;
    end
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1 d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    logic [31:0] st;
    cyc = 0;
    for (int i = 0; i < 300; i++) begin
      bus_read(2'd3, st);
      if (st[1] && !st[0]) return;
      @(posedge clk); #1;
      cyc++;
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic start_seq(input int n, input logic [31:0] ctrl);
    exp_q.push_back((n == 0) ? 1 : n);
    bus_write(2'd3, 32'h2);
    bus_write(2'd0, ctrl | 32'h1);
  endtask

  initial begin
    logic [31:0] rd;
    int cyc;

    // T1: reset state, then the automatic power-on sequence with 4/3 defaults.
    repeat (3) @(posedge clk);
    #1;
    check("rst_usb_rst_n", 32'(usb_rst_n), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    bus_read(2'd3, rd); check("rst_status", rd, 32'd0);
    bus_read(2'd1, rd); check("rst_assert", rd, 32'd4);
    bus_read(2'd2, rd); check("rst_settle", rd, 32'd3);
    exp_q.push_back(4);
    reset = 1'b0;
    @(posedge clk); #1;
    check("t1_low_after_start", 32'(usb_rst_n), 32'd0);
    wait_done(cyc);
    exp_seq++;
    check("t1_done_latency", 32'(cyc), 32'd7);
    bus_read(2'd3, rd);
    check("t1_seq_cnt", 32'(rd[15:8]), 32'(exp_seq % 256));
    check("t1_irq", 32'(irq), 32'd0);

    // T2: zero lengths behave as one cycle; irq follows done and W1C.
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd0);
    start_seq(0, 32'h4);
    wait_done(cyc);
    exp_seq++;
    check("t2_done_latency", 32'(cyc), 32'd2);
    check("t2_irq_up", 32'(irq), 32'd1);
    bus_write(2'd3, 32'h2);
    check("t2_irq_down", 32'(irq), 32'd0);

    // T3: start while busy sets ovr and does not disturb the running sequence.
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'd10);
    bus_write(2'd2, 32'd2);
    start_seq(10, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    bus_write(2'd0, 32'h1);
    wait_done(cyc);
    exp_seq++;
    bus_read(2'd3, rd);
    check("t3_ovr", 32'(rd[2]), 32'd1);
    check("t3_seq_cnt", 32'(rd[15:8]), 32'(exp_seq % 256));
    repeat (15) @(posedge clk);
    #1;
    bus_read(2'd3, rd);
    check("t3_no_restart", rd & 32'hFF01, 32'((exp_seq % 256) << 8));
    bus_write(2'd3, 32'h4);
    bus_read(2'd3, rd); check("t3_ovr_w1c", 32'(rd[2]), 32'd0);

    // T4: register writes mid-sequence only take effect on the next start.
    bus_write(2'd1, 32'd20);
    start_seq(20, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    bus_write(2'd1, 32'd5);
    wait_done(cyc);
    exp_seq++;
    bus_read(2'd1, rd); check("t4_assert_rb", rd, 32'd5);
    start_seq(5, 32'h0);
    wait_done(cyc);
    exp_seq++;
    check("t4_second_latency", 32'(cyc), 32'd7);

    // T5: hold forces the pin low while idle; reset mid-ASSERT returns everything to defaults.
    mon_en = 1'b0;
    bus_write(2'd0, 32'h2);
    check("t5_hold_low", 32'(usb_rst_n), 32'd0);
    bus_read(2'd3, rd); check("t5_hold_not_busy", 32'(rd[0]), 32'd0);
    bus_read(2'd0, rd); check("t5_ctrl_rb", rd, 32'h2);
    bus_write(2'd0, 32'h0);
    check("t5_hold_release", 32'(usb_rst_n), 32'd1);
    bus_write(2'd1, 32'd10);
    bus_write(2'd3, 32'h2);
    bus_write(2'd0, 32'h5);
    repeat (3) @(posedge clk);
    #1;
    check("t5_mid_assert_low", 32'(usb_rst_n), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_pin", 32'(usb_rst_n), 32'd1);
    check("t5_rst_irq", 32'(irq), 32'd0);
    bus_read(2'd3, rd); check("t5_rst_status", rd, 32'd0);
    bus_read(2'd0, rd); check("t5_rst_ctrl", rd, 32'd0);
    bus_read(2'd1, rd); check("t5_rst_assert", rd, 32'd4);
    @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b1;
    exp_seq = 0;
    exp_q.push_back(4);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    wait_done(cyc);
    exp_seq++;
    check("t5_auto_latency", 32'(cyc), 32'd7);

    // T6: sequence counter wraps; register readback masks bits above CNT_W.
    bus_write(2'd1, 32'd0);
    bus_write(2'd2, 32'd0);
    while (exp_seq != 256) begin
      start_seq(0, 32'h0);
      wait_done(cyc);
      exp_seq++;
      if (exp_seq == 128) begin
        bus_read(2'd3, rd);
        check("t6_seq_mid", 32'(rd[15:8]), 32'd128);
      end
    end
    bus_read(2'd3, rd);
    check("t6_seq_wrap", 32'(rd[15:8]), 32'd0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, rd); check("t6_assert_mask", rd, 32'h00FF_FFFF);
    bus_write(2'd2, 32'hABCD_EF12);
    bus_read(2'd2, rd); check("t6_settle_mask", rd, 32'h00CD_EF12);

    repeat (3) @(posedge clk);
    #1;
    check("pulse_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
